// File: rtl/axi_svm_multiclass_if.sv
// AXI4-Lite bus bundle for the multi-class SVM accelerator.
// Carries the five standard AXI4-Lite channels (AW, W, B, AR, R).
// The slave modport is used by axi_svm_multiclass and the master modport
// by whoever drives the register bus.
interface axi_svm_multiclass_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_svm_multiclass.sv
// One-vs-rest linear SVM accelerator behind an AXI4-Lite slave.
// Holds feature vector, per-class weights and biases; a sequential MAC engine
// computes one product per cycle and reports per-class scores, the argmax
// class, the run latency and a maskable done interrupt.
// Ports:
//   s_axi_aclk    clock
//   s_axi_aresetn asynchronous active-low reset
//   s_axi         AXI4-Lite slave (axi_svm_multiclass_if.slave), prot ignored
//   irq           level interrupt = STATUS.done & CONTROL.irq_en
module axi_svm_multiclass #(
  parameter int NUM_FEATURES       = 16,
  parameter int NUM_CLASSES        = 4,
  parameter int DATA_WIDTH         = 16,
  parameter int FRAC_BITS          = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi_svm_multiclass_if.slave   s_axi,
  output logic                  irq
);
  localparam int DW    = DATA_WIDTH;
  localparam int AXW   = C_S_AXI_DATA_WIDTH;
  localparam int FIW   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int CIW   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int ACC_W = 2 * DW + $clog2(NUM_FEATURES);
  localparam logic signed [ACC_W:0] SMAX = {{(ACC_W + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = {{(ACC_W + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {R_CTRL, R_STAT, R_LAT, R_BIAS, R_SCORE, R_FEAT, R_WGT, R_NONE} reg_e;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN} state_e;
  typedef struct packed {
    reg_e           kind;
    logic [CIW-1:0] c;
    logic [FIW-1:0] f;
  } dec_t;

  // Word-address decode; out-of-range class/feature indices map to R_NONE.
  function automatic dec_t decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    dec_t        d;
    logic [31:0] w, ci, fi;
    w  = 32'(a) >> 2;
    ci = '0;
    fi = '0;
    d  = '0;
    d.kind = R_NONE;
    if (w == 32'd0)      d.kind = R_CTRL;
    else if (w == 32'd1) d.kind = R_STAT;
    else if (w == 32'd2) d.kind = R_LAT;
    else if (w >= 32'd4 && w < 32'd16) begin
      ci = w - 32'd4;
      if (ci < NUM_CLASSES) d.kind = R_BIAS;
    end else if (w >= 32'd16 && w < 32'd32) begin
      ci = w - 32'd16;
      if (ci < NUM_CLASSES) d.kind = R_SCORE;
    end else if (w >= 32'd64 && w < 32'd96) begin
      fi = w - 32'd64;
      if (fi < NUM_FEATURES) d.kind = R_FEAT;
    end else if (w >= 32'd256 && w < 32'd512) begin
      ci = (w - 32'd256) >> 5;
      fi = (w - 32'd256) & 32'd31;
      if (ci < NUM_CLASSES && fi < NUM_FEATURES) d.kind = R_WGT;
    end
    d.c = CIW'(ci);
    d.f = FIW'(fi);
    return d;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [AXW-1:0] wd,
                                          input logic [AXW/8-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int unsigned i = 0; i < DW; i++) if (st[i/8]) r[i] = wd[i];
    return r;
  endfunction

  // Register banks
  logic signed [DW-1:0] feat_q  [NUM_FEATURES];
  logic signed [DW-1:0] wgt_q   [NUM_CLASSES][NUM_FEATURES];
  logic signed [DW-1:0] bias_q  [NUM_CLASSES];
  logic signed [DW-1:0] score_q [NUM_CLASSES];
  logic                 irq_en_q;

  // Engine state
  state_e                  state_q;
  logic [CIW-1:0]          c_q, best_c_q;
  logic [FIW-1:0]          f_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [DW-1:0]    best_q;
  logic                    busy_q, done_q;
  logic [2:0]              class_q;
  logic [31:0]             lat_cnt_q, latency_q;

  // AXI channel registers
  logic            awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [AXW-1:0]  rdata_q;

  dec_t wdec, rdec;
  logic wr_en, rd_en, wr_bank, wr_err, bank_we, start_p, soft_p, done_clr;

  assign wdec     = decode(s_axi.awaddr);
  assign rdec     = decode(s_axi.araddr);
  assign wr_en    = awready_q & s_axi.awvalid & s_axi.wvalid;
  assign rd_en    = arready_q & s_axi.arvalid;
  assign wr_bank  = (wdec.kind == R_BIAS) | (wdec.kind == R_FEAT) | (wdec.kind == R_WGT);
  assign wr_err   = (wdec.kind == R_NONE) | (wr_bank & busy_q);
  assign bank_we  = wr_en & wr_bank & ~busy_q;
  assign start_p  = wr_en & (wdec.kind == R_CTRL) & s_axi.wstrb[0] & s_axi.wdata[0];
  assign soft_p   = wr_en & (wdec.kind == R_CTRL) & s_axi.wstrb[0] & s_axi.wdata[1];
  assign done_clr = wr_en & (wdec.kind == R_STAT) & s_axi.wstrb[0] & s_axi.wdata[0];

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign irq           = done_q & irq_en_q;

  // Datapath for the current MAC / FIN cycle
  logic signed [2*DW-1:0] prod_d;
  logic signed [ACC_W:0]  sum_d;
  logic signed [DW-1:0]   score_d;
  logic                   take_d;
  logic [CIW-1:0]         best_c_d;

  always_comb begin
    prod_d   = feat_q[f_q] * wgt_q[c_q][f_q];
    sum_d    = (ACC_W + 1)'(acc_q >>> FRAC_BITS) + (ACC_W + 1)'(bias_q[c_q]);
    if (sum_d > SMAX)      score_d = DW'(SMAX);
    else if (sum_d < SMIN) score_d = DW'(SMIN);
    else                   score_d = DW'(sum_d);
    take_d   = (c_q == '0) || (score_d > best_q);
    best_c_d = take_d ? c_q : best_c_q;
  end

  // AXI4-Lite handshakes
  logic [AXW-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (rdec.kind)
      R_CTRL:  rd_val = AXW'({irq_en_q, 2'b00});
      R_STAT:  rd_val = AXW'({class_q, 6'b0, busy_q, done_q});
      R_LAT:   rd_val = AXW'(latency_q);
      R_BIAS:  rd_val = AXW'(bias_q[rdec.c]);
      R_SCORE: rd_val = AXW'(score_q[rdec.c]);
      R_FEAT:  rd_val = AXW'(feat_q[rdec.f]);
      R_WGT:   rd_val = AXW'(wgt_q[rdec.c][rdec.f]);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      wready_q  <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= s_axi.arvalid & ~rvalid_q & ~arready_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rresp_q  <= (rdec.kind == R_NONE) ? 2'b10 : 2'b00;
        rdata_q  <= rd_val;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Configuration banks; soft reset leaves these untouched
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      irq_en_q <= 1'b0;
      for (int unsigned f = 0; f < NUM_FEATURES; f++) feat_q[f] <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        bias_q[c] <= '0;
        for (int unsigned f = 0; f < NUM_FEATURES; f++) wgt_q[c][f] <= '0;
      end
    end else begin
      if (wr_en && wdec.kind == R_CTRL && s_axi.wstrb[0]) irq_en_q <= s_axi.wdata[2];
      if (bank_we) begin
        case (wdec.kind)
          R_BIAS:  bias_q[wdec.c] <= merge(bias_q[wdec.c], s_axi.wdata, s_axi.wstrb);
          R_FEAT:  feat_q[wdec.f] <= merge(feat_q[wdec.f], s_axi.wdata, s_axi.wstrb);
          R_WGT:   wgt_q[wdec.c][wdec.f] <= merge(wgt_q[wdec.c][wdec.f], s_axi.wdata, s_axi.wstrb);
          default: ;
        endcase
      end
    end
  end

  // MAC engine FSM
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      f_q       <= '0;
      acc_q     <= '0;
      best_q    <= '0;
      best_c_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      class_q   <= '0;
      lat_cnt_q <= '0;
      latency_q <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) score_q[c] <= '0;
    end else if (soft_p) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      class_q   <= '0;
      latency_q <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) score_q[c] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_p) begin
            state_q   <= S_MAC;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            latency_q <= '0;
            lat_cnt_q <= '0;
            c_q       <= '0;
            f_q       <= '0;
            acc_q     <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) score_q[c] <= '0;
          end else if (done_clr) begin
            done_q <= 1'b0;
          end
        end
        S_MAC: begin
          acc_q     <= acc_q + ACC_W'(prod_d);
          lat_cnt_q <= lat_cnt_q + 32'd1;
          if (f_q == FIW'(NUM_FEATURES - 1)) state_q <= S_FIN;
          else                               f_q     <= f_q + 1'b1;
        end
        S_FIN: begin
          lat_cnt_q    <= lat_cnt_q + 32'd1;
          score_q[c_q] <= score_d;
          if (take_d) best_q <= score_d;
          best_c_q     <= best_c_d;
          // The last FIN folds its own score into the argmax before publishing.
          if (c_q == CIW'(NUM_CLASSES - 1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            class_q   <= 3'(best_c_d);
            latency_q <= lat_cnt_q + 32'd1;
          end else begin
            c_q     <= c_q + 1'b1;
            f_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_svm_multiclass.sv
module tb_axi_svm_multiclass;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_svm_multiclass_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axi_svm_multiclass #(
    .NUM_FEATURES(16), .NUM_CLASSES(4), .DATA_WIDTH(16), .FRAC_BITS(8),
    .C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .s_axi(bus), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    int n;
    resp = 2'b11;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
    if (!bus.awready) chk("aw_timeout", 32'(bus.awready), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) chk("b_timeout", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    d = 'x; resp = 2'b11;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
    if (!bus.arready) chk("ar_timeout", 32'(bus.arready), 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.rvalid) chk("r_timeout", 32'(bus.rvalid), 32'd1);
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_wr(a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    chk(tag, d, exp);
  endtask

  task automatic wait_done();
    logic [31:0] st;
    logic [1:0]  r;
    int          n;
    st = '0; n = 0;
    while (!st[0] && n < 200) begin axi_rd(12'h004, st, r); n++; end
    if (!st[0]) chk("done_timeout", 32'(st[0]), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_irq",     32'(irq),         32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic run: one class at 0.5*1.0*16 = 8.0
    for (int f = 0; f < 16; f++) begin
      wr(12'(12'h100 + 4*f), 32'h0100);
      wr(12'(12'h400 + 4*f), 32'h0080);
    end
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("score0_basic", 12'h040, 32'h0000_0800);
    rd_chk("score1_basic", 12'h044, 32'h0);
    rd_chk("score3_basic", 12'h04C, 32'h0);
    rd_chk("status_basic", 12'h004, 32'h0000_0001);
    rd_chk("latency",      12'h008, 32'd68);

    // Bias pushes class 2 over, then tie between 1 and 2 picks 1
    wr(12'h018, 32'h0A00);
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("score2_bias",  12'h048, 32'h0000_0A00);
    rd_chk("status_cls2",  12'h004, 32'h0000_0201);
    wr(12'h014, 32'h0A00);
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("status_tie",   12'h004, 32'h0000_0101);
    wr(12'h014, 32'h0);
    wr(12'h018, 32'h0);

    // Saturation both ways
    for (int f = 0; f < 16; f++) begin
      wr(12'(12'h100 + 4*f), 32'h7FFF);
      wr(12'(12'h400 + 4*f), 32'h7FFF);
    end
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("score0_satpos", 12'h040, 32'h0000_7FFF);
    for (int f = 0; f < 16; f++) wr(12'(12'h400 + 4*f), 32'h8001);
    rd_chk("wgt_signext", 12'h400, 32'hFFFF_8001);
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("score0_satneg", 12'h040, 32'hFFFF_8000);
    rd_chk("status_satneg", 12'h004, 32'h0000_0101);

    // Bank write while busy is refused; unmapped read errors
    wr(12'h000, 32'h1);
    axi_wr(12'h48C, 32'h1234, 4'hF, r);
    chk("busy_wr_bresp", 32'(r), 32'd2);
    wait_done();
    rd_chk("busy_wr_unchanged", 12'h48C, 32'h0);
    axi_rd(12'h0F0, d, r);
    chk("unmapped_rresp", 32'(r), 32'd2);
    chk("unmapped_rdata", d, 32'h0);

    // Interrupt and write-1-clear
    wr(12'h000, 32'h5);
    wait_done();
    chk("irq_set", 32'(irq), 32'd1);
    wr(12'h004, 32'h1);
    chk("irq_clr", 32'(irq), 32'd0);
    rd_chk("status_clr", 12'h004, 32'h0000_0100);

    // Soft reset mid-run, then rerun
    wr(12'h000, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    wr(12'h000, 32'h2);
    rd_chk("soft_status", 12'h004, 32'h0);
    rd_chk("soft_score0", 12'h040, 32'h0);
    rd_chk("soft_latency", 12'h008, 32'h0);
    rd_chk("soft_wgt", 12'h414, 32'hFFFF_8001);
    rd_chk("soft_feat", 12'h108, 32'h0000_7FFF);
    wr(12'h000, 32'h1);
    wait_done();
    rd_chk("rerun_score0", 12'h040, 32'hFFFF_8000);
    rd_chk("rerun_status", 12'h004, 32'h0000_0101);
    rd_chk("rerun_latency", 12'h008, 32'd68);
    wr(12'h000, 32'h3);
    rd_chk("start_soft_status", 12'h004, 32'h0);

    // Byte strobes, out-of-range indices
    axi_wr(12'h100, 32'h0000_ABCD, 4'b0001, r);
    rd_chk("strb_lo", 12'h100, 32'h0000_7FCD);
    axi_wr(12'h010, 32'h0000_9900, 4'b0010, r);
    rd_chk("strb_hi", 12'h010, 32'hFFFF_9900);
    axi_wr(12'h600, 32'h1, 4'hF, r);
    chk("oor_class_bresp", 32'(r), 32'd2);
    axi_wr(12'h140, 32'h1, 4'hF, r);
    chk("oor_feat_bresp", 32'(r), 32'd2);

    // Asynchronous reset while a write response is pending
    bus.awaddr = 12'h400; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < 50);
    if (!bus.bvalid) chk("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
    rst_n = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    #1;
    chk("arst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("arst_awready", 32'(bus.awready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd_chk("arst_feat0", 12'h100, 32'h0);
    rd_chk("arst_wgt00", 12'h400, 32'h0);
    rd_chk("arst_bias0", 12'h010, 32'h0);
    rd_chk("arst_wgt3f", 12'h5BC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_svm_multiclass.md
# axi_svm_multiclass

AXI4-Lite-mapped, parametrised multi-class (one-vs-rest) linear SVM accelerator. It holds a per-class weight bank, per-class bias and one shared feature vector in registers. It runs a sequential fixed-point multiply-accumulate engine, one product per cycle, and reports every class score, the argmax class, the cycle latency and a maskable completion interrupt. It sits on the PS control bus in place of the single-class wrapper and needs no external core.

## Interface
- NUM_FEATURES, 16: features per vector, 1..32
- NUM_CLASSES, 4: classes, 1..8
- DATA_WIDTH, 16: signed Q-format width of features, weights, biases and scores
- FRAC_BITS, 8: fractional bits
- C_S_AXI_ADDR_WIDTH, 12: byte address width
- C_S_AXI_DATA_WIDTH, 32: fixed
- s_axi_aclk  in  1  single clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- s_axi_aw{addr,prot,valid}/awready, s_axi_w{data,strb,valid}/wready, s_axi_b{resp,valid}/bready, s_axi_ar{addr,prot,valid}/arready, s_axi_r{data,resp,valid}/rready: standard AXI4-Lite slave; prot is ignored
- irq  out  1  level interrupt = STATUS.done & CONTROL.irq_en

## Operation
- Register map (byte offsets):
  - 0x000 CONTROL: bit0 start, bit1 soft_reset, bit2 irq_en. start and soft_reset are write-1 pulses and read 0.
  - 0x004 STATUS: bit0 done (write 1 to clear), bit1 busy, bits[10:8] class. Read-only except done.
  - 0x008 LATENCY: RO.
  - 0x010+4c BIAS[c]: RW.
  - 0x040+4c SCORE[c]: RO, sign-extended.
  - 0x100+4f FEATURE[f]: RW.
  - 0x400+0x80c+4f WEIGHT[c][f]: RW.
  - RW registers store DATA_WIDTH bits, read back sign-extended, and honour wstrb per byte.
- Decode and responses:
  - Unmapped address, or index ≥ NUM_CLASSES/NUM_FEATURES: SLVERR; read data 0; write has no effect.
  - Write to BIAS/FEATURE/WEIGHT while busy: SLVERR; not applied.
- FSM states:
  - IDLE: start → MAC. Clears done, SCORE and LATENCY. Sets busy. Sets c=0, f=0, acc=0.
  - MAC: acc += FEATURE[f]*WEIGHT[c][f], one per cycle. After f=NUM_FEATURES-1 → FIN.
  - FIN:
    - score = sat((acc >>> FRAC_BITS) + BIAS[c]); the shift is arithmetic and floors.
    - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
    - Write SCORE[c].
    - Update the argmax: a strictly greater score replaces it, so ties keep the lowest index; c=0 initialises it.
    - If c < NUM_CLASSES-1: c++, f=0, acc=0, → MAC. Otherwise → IDLE with done=1, busy=0, class=argmax.
- Accumulator width 2·DW + clog2(NUM_FEATURES); no overflow inside it.
- LATENCY counts busy cycles and is written when done sets.
- start while busy is ignored (OKAY response). Write-1-clear of done while busy has no effect.
- Soft reset:
  - Aborts any run; FSM → IDLE.
  - Clears busy, done, class, SCORE[] and LATENCY.
  - Keeps weights, features, biases and irq_en.
  - If start and soft_reset are written together, soft_reset wins.
- Hard reset clears all registers, including the banks, to 0.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid, irq: 0.
  - bresp, rresp, rdata: 0.
- Write handshake:
  - Accepted when awvalid & wvalid & !bvalid; awready and wready pulse high for 1 cycle (T).
  - Register updates at the T edge.
  - bvalid rises at T+1 and holds until bready.
  - No new write is accepted while bvalid is high.
- Read handshake:
  - arready pulses for 1 cycle when arvalid & !rvalid.
  - rdata/rresp/rvalid are registered at the next cycle, sampled from the address captured with arready.
  - rvalid holds until rready.
- Start accepted at T → busy=1 from T+1.
- Busy lasts exactly NUM_CLASSES·(NUM_FEATURES+1) cycles (68 at defaults).
- done, class and irq rise in the same cycle busy falls.
- SCORE[c] is visible one cycle after its FIN cycle.
- A read of STATUS in the same cycle done sets returns the pre-update value.
- Reads and writes proceed concurrently with the engine. Independent read/write channels may handshake in the same cycle.
- Asynchronous reset deasserts all outputs immediately, mid-transaction included.

## Test plan
- All FEATURE=0x0100, WEIGHT[0][*]=0x0080, other weights 0, biases 0; start → SCORE0=0x00000800, other scores 0, class=0, LATENCY=68, done=1.
- As above plus BIAS[2]=0x0A00 → SCORE2=0x00000A00, class=2. Then BIAS[1]=0x0A00 as well → class=1 (tie resolves to the lowest index).
- FEATURE=0x7FFF, WEIGHT[0][*]=0x7FFF → SCORE0=0x00007FFF. WEIGHT[0][*]=0x8001 → SCORE0=0xFFFF8000.
- Write WEIGHT[1][3] during busy → bresp=SLVERR, read-back unchanged. Read 0x0F0 → rresp=SLVERR, rdata=0.
- irq_en=1, run → irq=1. Write STATUS=1 → done=0 and irq=0 next cycle.
- Soft reset 20 cycles into a run → busy=0, SCOREs=0, weights intact. A rerun gives identical results. Assert s_axi_aresetn mid-write → bvalid=0 and all banks read back 0.
